icm_lookup_arbiter: RTL and testbench
=====================================

ICM_LOOKUP_ARBITER -- requirements
Module: icm_lookup_arbiter

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  IDX_W, 16, ICM entry index width of a lookup head
  ICM_ADDR_W, 64, ICM space address width
  PHY_ADDR_W, 64, physical address width
  TIMEOUT_CYCLES, 1024, response watchdog limit (used only with ICM_ARB_TIMEOUT_EN)
REQ-002 Ports, one per line (name direction width meaning):
  clk  in  1  single clock
  rst  in  1  reset, synchronous, active-high
  req_lookup_valid  in  2  per-requester lookup request (bit0 = MPT write thread, bit1 = MTT write thread)
  req_lookup_head  in  2*IDX_W  per-requester index; requester n at [n*IDX_W +: IDX_W]
  req_lookup_ready  out  2  per-requester accept
  req_rsp_valid  out  2  response valid, routed to owner only
  req_rsp_icm_addr  out  ICM_ADDR_W  response ICM address, broadcast
  req_rsp_phy_addr  out  PHY_ADDR_W  response physical address, broadcast
  req_rsp_ready  in  2  per-requester response accept
  icm_mapping_lookup_valid  out  1  downstream lookup request
  icm_mapping_lookup_head  out  IDX_W  downstream index
  icm_mapping_lookup_ready  in  1  downstream accept
  icm_mapping_rsp_valid  in  1  downstream response valid
  icm_mapping_rsp_icm_addr  in  ICM_ADDR_W  downstream ICM address
  icm_mapping_rsp_phy_addr  in  PHY_ADDR_W  downstream physical address
  icm_mapping_rsp_ready  out  1  downstream response accept
  busy  out  1  high in any state other than IDLE
  timeout_err  out  1  one-cycle pulse on watchdog expiry

Function
REQ-003 FSM states IDLE, LOOKUP, WAIT_RSP; exactly one lookup outstanding at a time.
REQ-004 IDLE: if any req_lookup_valid bit set, grant one requester; req_lookup_ready[grant] high combinationally that cycle, other bit low; latch owner and head; next state LOOKUP.
REQ-005 Arbitration round-robin: single request wins; both valid -> requester not granted last wins; last-grant pointer resets to 1 (requester 0 wins first tie).
REQ-006 LOOKUP: icm_mapping_lookup_valid = 1, head = latched head; on lookup_valid && lookup_ready -> WAIT_RSP; head stable while waiting.
REQ-007 icm_mapping_lookup_head = 0 and req_lookup_ready = 0 outside their active states.
REQ-008 WAIT_RSP: req_rsp_valid[owner] = icm_mapping_rsp_valid, other bit 0; icm_mapping_rsp_ready = req_rsp_ready[owner]; addresses pass through combinationally (zero latency).
REQ-009 Response handshake (rsp_valid && rsp_ready) in WAIT_RSP -> IDLE, last-grant pointer <= owner; new grant possible in that next IDLE cycle (min. 3 cycles per lookup with zero-wait downstream).
REQ-010 icm_mapping_rsp_ready = 0 and req_rsp_valid = 0 outside WAIT_RSP; a downstream response in IDLE/LOOKUP is not accepted.
REQ-011 Requester deasserting valid after grant has no effect; latched request completes.
REQ-012 Owner not ready in WAIT_RSP: hold state, downstream rsp_ready low (backpressure).

Reset
REQ-013 rst sampled on clk only; while high: state IDLE, owner 0, latched head 0, last-grant 1, watchdog counter 0.
REQ-014 Reset values of outputs: all valid/ready outputs 0, heads/addresses forwarded as 0 except broadcast addresses (pass-through of inputs), busy 0, timeout_err 0.
REQ-015 Reset mid-operation aborts the outstanding lookup; no response is forwarded after reset deasserts; requester restarts its request.

Configuration
REQ-016 Macro ICM_ARB_TIMEOUT_EN defined: counter increments each WAIT_RSP cycle without response handshake, clears on state entry; reaching TIMEOUT_CYCLES -> timeout_err high one cycle, state IDLE, pointer <= owner, response dropped.
REQ-017 Macro undefined: no counter logic; WAIT_RSP waits indefinitely; timeout_err tied 0; port list unchanged.

Verification
REQ-018 Only bit0 valid, head 0x0012, downstream ready, rsp 2 cycles later icm 0x1000/phy 0x8000_0000 -> bit0 rsp_valid with those addresses, bit1 never valid, busy 0 after handshake.
REQ-019 Both valid continuously, heads 0x0001/0x0002, five lookups -> downstream heads 0x0001,0x0002,0x0001,0x0002,0x0001.
REQ-020 icm_mapping_lookup_ready low 4 cycles in LOOKUP -> lookup_valid held, head stable, single lookup handshake.
REQ-021 Owner req_rsp_ready low 3 cycles while rsp_valid high -> icm_mapping_rsp_ready low for those cycles, state WAIT_RSP, then completes.
REQ-022 rst pulsed one cycle in WAIT_RSP, then rsp_valid -> no req_rsp_valid, rsp_ready 0, state IDLE.
REQ-023 With ICM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no response -> timeout_err pulse exactly 8 cycles after WAIT_RSP entry, next pending request granted; without macro -> stays busy, timeout_err 0.

Source files
------------

// File: rtl/icm_lookup_arbiter_if.sv
// Requester/downstream bus bundle for icm_lookup_arbiter.
// master = arbiter view, slave = environment view (requesters plus ICM mapping table).
interface icm_lookup_arbiter_if #(
  parameter int unsigned IDX_W      = 16,
  parameter int unsigned ICM_ADDR_W = 64,
  parameter int unsigned PHY_ADDR_W = 64
);
  logic [1:0]            req_lookup_valid;
  logic [2*IDX_W-1:0]    req_lookup_head;
  logic [1:0]            req_lookup_ready;
  logic [1:0]            req_rsp_valid;
  logic [ICM_ADDR_W-1:0] req_rsp_icm_addr;
  logic [PHY_ADDR_W-1:0] req_rsp_phy_addr;
  logic [1:0]            req_rsp_ready;
  logic                  icm_mapping_lookup_valid;
  logic [IDX_W-1:0]      icm_mapping_lookup_head;
  logic                  icm_mapping_lookup_ready;
  logic                  icm_mapping_rsp_valid;
  logic [ICM_ADDR_W-1:0] icm_mapping_rsp_icm_addr;
  logic [PHY_ADDR_W-1:0] icm_mapping_rsp_phy_addr;
  logic                  icm_mapping_rsp_ready;

  modport master (
    input  req_lookup_valid, req_lookup_head, req_rsp_ready,
    input  icm_mapping_lookup_ready, icm_mapping_rsp_valid,
    input  icm_mapping_rsp_icm_addr, icm_mapping_rsp_phy_addr,
    output req_lookup_ready, req_rsp_valid, req_rsp_icm_addr, req_rsp_phy_addr,
    output icm_mapping_lookup_valid, icm_mapping_lookup_head, icm_mapping_rsp_ready
  );

  modport slave (
    output req_lookup_valid, req_lookup_head, req_rsp_ready,
    output icm_mapping_lookup_ready, icm_mapping_rsp_valid,
    output icm_mapping_rsp_icm_addr, icm_mapping_rsp_phy_addr,
    input  req_lookup_ready, req_rsp_valid, req_rsp_icm_addr, req_rsp_phy_addr,
    input  icm_mapping_lookup_valid, icm_mapping_lookup_head, icm_mapping_rsp_ready
  );
endinterface

// File: rtl/icm_lookup_arbiter.sv
// Two-requester round-robin arbiter in front of the ICM mapping lookup; one lookup in flight.
// Optional response watchdog enabled by defining ICM_ARB_TIMEOUT_EN.
module icm_lookup_arbiter #(
  parameter int unsigned IDX_W          = 16,
  parameter int unsigned ICM_ADDR_W     = 64,
  parameter int unsigned PHY_ADDR_W     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  icm_lookup_arbiter_if.master bus,
  output logic                 busy,
  output logic                 timeout_err
);

  typedef enum logic [1:0] {IDLE, LOOKUP, WAIT_RSP} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic [IDX_W-1:0] head_q, head_d;
  logic             last_q, last_d;
  logic             gnt;
  logic [IDX_W-1:0] gnt_head;
  logic             owner_rdy;
  logic             rsp_hs;
  logic             wd_expire;

  logic [ICM_ADDR_W-1:0] icm_addr;
  logic [PHY_ADDR_W-1:0] phy_addr;

  // Addresses are broadcast unconditionally; only the valid is routed to the owner.
  assign icm_addr             = bus.icm_mapping_rsp_icm_addr;
  assign phy_addr             = bus.icm_mapping_rsp_phy_addr;
  assign bus.req_rsp_icm_addr = icm_addr;
  assign bus.req_rsp_phy_addr = phy_addr;

  always_comb begin
    gnt = 1'b0;
    if (bus.req_lookup_valid == 2'b10)
      gnt = 1'b1;
    else if (bus.req_lookup_valid == 2'b11)
      gnt = ~last_q;
  end

  assign gnt_head  = gnt ? bus.req_lookup_head[IDX_W +: IDX_W]
                         : bus.req_lookup_head[0 +: IDX_W];
  assign owner_rdy = bus.req_rsp_ready[owner_q];
  assign rsp_hs    = (state_q == WAIT_RSP) && bus.icm_mapping_rsp_valid && owner_rdy;
  assign busy      = (state_q != IDLE);

`ifdef ICM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt_q;
  logic             timeout_q;

  // Expiry is detected in the cycle whose increment would reach the limit.
  assign wd_expire = (state_q == WAIT_RSP) && !rsp_hs &&
                     (wd_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_expire;
      if ((state_q != WAIT_RSP) || rsp_hs || wd_expire)
        wd_cnt_q <= '0;
      else
        wd_cnt_q <= wd_cnt_q + CNT_W'(1);
    end
  end

  assign timeout_err = timeout_q;
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      head_q  <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      head_q  <= head_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    head_d  = head_q;
    last_d  = last_q;
    bus.req_lookup_ready         = '0;
    bus.req_rsp_valid            = '0;
    bus.icm_mapping_lookup_valid = 1'b0;
    bus.icm_mapping_lookup_head  = '0;
    bus.icm_mapping_rsp_ready    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|bus.req_lookup_valid) begin
          bus.req_lookup_ready[gnt] = 1'b1;
          owner_d = gnt;
          head_d  = gnt_head;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        bus.icm_mapping_lookup_valid = 1'b1;
        bus.icm_mapping_lookup_head  = head_q;
        if (bus.icm_mapping_lookup_ready)
          state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        bus.req_rsp_valid[owner_q] = bus.icm_mapping_rsp_valid;
        bus.icm_mapping_rsp_ready  = owner_rdy;
        if (rsp_hs || wd_expire) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_icm_lookup_arbiter.sv
// Directed bench for icm_lookup_arbiter; inputs driven on the falling edge, outputs checked 1ns later.
module tb_icm_lookup_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic timeout_err;
  int   errors = 0;
  int   checks = 0;

  logic [15:0] exp_head [5];
  logic [1:0]  exp_onehot [5];

  always #5 clk = ~clk;

  icm_lookup_arbiter_if #(.IDX_W(16), .ICM_ADDR_W(64), .PHY_ADDR_W(64)) bus ();

  icm_lookup_arbiter #(
    .IDX_W(16),
    .ICM_ADDR_W(64),
    .PHY_ADDR_W(64),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    exp_head   = '{16'h0001, 16'h0002, 16'h0001, 16'h0002, 16'h0001};
    exp_onehot = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};

    rst = 1'b1;
    bus.req_lookup_valid         = '0;
    bus.req_lookup_head          = '0;
    bus.req_rsp_ready            = 2'b11;
    bus.icm_mapping_lookup_ready = 1'b1;
    bus.icm_mapping_rsp_valid    = 1'b1;
    bus.icm_mapping_rsp_icm_addr = 64'h55;
    bus.icm_mapping_rsp_phy_addr = 64'hAA;
    @(negedge clk);
    @(negedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_lookup_ready", bus.req_lookup_ready, 0);
    chk("rst_dn_valid", bus.icm_mapping_lookup_valid, 0);
    chk("rst_dn_head", bus.icm_mapping_lookup_head, 0);
    chk("rst_rsp_valid", bus.req_rsp_valid, 0);
    chk("rst_dn_rsp_ready", bus.icm_mapping_rsp_ready, 0);
    chk("rst_icm_pass", bus.req_rsp_icm_addr, 64'h55);
    chk("rst_phy_pass", bus.req_rsp_phy_addr, 64'hAA);

    // Single requester, response two cycles into WAIT_RSP
    @(negedge clk);
    rst = 1'b0;
    bus.icm_mapping_rsp_valid = 1'b0;
    bus.req_lookup_valid = 2'b01;
    bus.req_lookup_head  = 32'h0000_0012; #1;
    chk("t1_grant", bus.req_lookup_ready, 2'b01);
    chk("t1_idle_busy", busy, 0);
    @(negedge clk);
    bus.req_lookup_valid = 2'b00; #1;
    chk("t1_dn_valid", bus.icm_mapping_lookup_valid, 1);
    chk("t1_dn_head", bus.icm_mapping_lookup_head, 16'h0012);
    chk("t1_busy", busy, 1);
    chk("t1_ready_low", bus.req_lookup_ready, 0);
    @(negedge clk); #1;
    chk("t1_wait_no_rsp", bus.req_rsp_valid, 0);
    chk("t1_wait_dn_valid", bus.icm_mapping_lookup_valid, 0);
    chk("t1_wait_dn_head", bus.icm_mapping_lookup_head, 0);
    @(negedge clk);
    bus.icm_mapping_rsp_valid    = 1'b1;
    bus.icm_mapping_rsp_icm_addr = 64'h1000;
    bus.icm_mapping_rsp_phy_addr = 64'h8000_0000; #1;
    chk("t1_rsp_valid", bus.req_rsp_valid, 2'b01);
    chk("t1_rsp_icm", bus.req_rsp_icm_addr, 64'h1000);
    chk("t1_rsp_phy", bus.req_rsp_phy_addr, 64'h8000_0000);
    chk("t1_dn_rsp_ready", bus.icm_mapping_rsp_ready, 1);
    @(negedge clk);
    bus.icm_mapping_rsp_valid = 1'b0; #1;
    chk("t1_done_busy", busy, 0);
    chk("t1_done_rsp_valid", bus.req_rsp_valid, 0);

    // Round-robin with both requesting continuously and a zero-wait downstream
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req_lookup_valid      = 2'b11;
    bus.req_lookup_head       = 32'h0002_0001;
    bus.icm_mapping_rsp_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_grant", bus.req_lookup_ready, exp_onehot[i]);
      @(negedge clk); #1;
      chk("t2_dn_head", bus.icm_mapping_lookup_head, exp_head[i]);
      chk("t2_lookup_no_rsp_ready", bus.icm_mapping_rsp_ready, 0);
      chk("t2_lookup_no_rsp_valid", bus.req_rsp_valid, 0);
      @(negedge clk); #1;
      chk("t2_rsp_route", bus.req_rsp_valid, exp_onehot[i]);
      @(negedge clk);
    end
    bus.req_lookup_valid      = 2'b00;
    bus.icm_mapping_rsp_valid = 1'b0;

    // Downstream holds off the lookup for four cycles
    @(negedge clk);
    bus.req_lookup_valid         = 2'b10;
    bus.req_lookup_head          = 32'h00AB_0000;
    bus.icm_mapping_lookup_ready = 1'b0; #1;
    chk("t3_grant", bus.req_lookup_ready, 2'b10);
    @(negedge clk);
    bus.req_lookup_valid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_hold_valid", bus.icm_mapping_lookup_valid, 1);
      chk("t3_hold_head", bus.icm_mapping_lookup_head, 16'h00AB);
      @(negedge clk);
    end
    bus.icm_mapping_lookup_ready = 1'b1; #1;
    chk("t3_accept_valid", bus.icm_mapping_lookup_valid, 1);
    @(negedge clk); #1;
    chk("t3_single_hs", bus.icm_mapping_lookup_valid, 0);
    chk("t3_wait_busy", busy, 1);

    // Owner (requester 1) backpressures the response for three cycles
    bus.icm_mapping_rsp_valid    = 1'b1;
    bus.icm_mapping_rsp_icm_addr = 64'h2000;
    bus.req_rsp_ready            = 2'b01;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t4_bp_dn_ready", bus.icm_mapping_rsp_ready, 0);
      chk("t4_bp_rsp_valid", bus.req_rsp_valid, 2'b10);
      chk("t4_bp_busy", busy, 1);
      @(negedge clk);
    end
    bus.req_rsp_ready = 2'b11; #1;
    chk("t4_release_dn_ready", bus.icm_mapping_rsp_ready, 1);
    chk("t4_release_icm", bus.req_rsp_icm_addr, 64'h2000);
    @(negedge clk);
    bus.icm_mapping_rsp_valid = 1'b0; #1;
    chk("t4_done_busy", busy, 0);

    // Reset pulse while waiting for the response aborts the lookup
    bus.req_lookup_valid = 2'b01;
    bus.req_lookup_head  = 32'h0000_0033; #1;
    chk("t5_grant", bus.req_lookup_ready, 2'b01);
    @(negedge clk);
    bus.req_lookup_valid = 2'b00;
    @(negedge clk); #1;
    chk("t5_wait_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.icm_mapping_rsp_valid = 1'b1; #1;
    chk("t5_no_rsp_valid", bus.req_rsp_valid, 0);
    chk("t5_no_dn_ready", bus.icm_mapping_rsp_ready, 0);
    chk("t5_idle", busy, 0);
    @(negedge clk); #1;
    chk("t5_still_no_rsp", bus.req_rsp_valid, 0);
    chk("t5_still_idle", busy, 0);
    bus.icm_mapping_rsp_valid = 1'b0;

    // No response at all; requester 1 pending behind the stalled lookup
    bus.req_lookup_valid = 2'b01;
    bus.req_lookup_head  = 32'h0000_0044; #1;
    chk("t6_grant", bus.req_lookup_ready, 2'b01);
    @(negedge clk);
    bus.req_lookup_valid = 2'b10;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t6_wait_busy", busy, 1);
      chk("t6_wait_no_timeout", timeout_err, 0);
      @(negedge clk);
    end
`ifdef ICM_ARB_TIMEOUT_EN
    #1;
    chk("t6_timeout_pulse", timeout_err, 1);
    chk("t6_timeout_idle", busy, 0);
    chk("t6_next_grant", bus.req_lookup_ready, 2'b10);
    @(negedge clk); #1;
    chk("t6_pulse_one_cycle", timeout_err, 0);
    chk("t6_next_lookup_busy", busy, 1);
    chk("t6_next_head", bus.icm_mapping_lookup_head, 16'h0000);
`else
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t6_still_busy", busy, 1);
      chk("t6_no_timeout", timeout_err, 0);
      chk("t6_no_grant", bus.req_lookup_ready, 0);
      @(negedge clk);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
